// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - direct-mapped cache lookup and line refill sequencer
module cache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16,
    localparam int OFF_W     = $clog2(LINE_WORDS),
    localparam int IDX_W     = $clog2(NUM_LINES),
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [ADDR_W-1:0]      req_addr_i,
    output logic                   resp_valid_o,
    output logic [DATA_W-1:0]      resp_data_o,
    input  logic                   flush_i,
    output logic                   arr_we_o,
    output logic [IDX_W+OFF_W-1:0] arr_addr_o,
    output logic [DATA_W-1:0]      arr_wdata_o,
    input  logic [DATA_W-1:0]      arr_rdata_i,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [ADDR_W-1:0]      mem_addr_o,
    input  logic                   mem_rvalid_i,
    input  logic [DATA_W-1:0]      mem_rdata_i,
    output logic [15:0]            hit_cnt_o,
    output logic [15:0]            miss_cnt_o
);

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND} state_t;

    state_t               state;
    logic [TAG_W-1:0]     tag_q;
    logic [IDX_W-1:0]     idx_q;
    logic [OFF_W-1:0]     off_q;
    logic [OFF_W-1:0]     cnt;
    logic [DATA_W-1:0]    resp_q;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags [NUM_LINES];
    logic                 flush_pend;
    logic [15:0]          hit_cnt;
    logic [15:0]          miss_cnt;

    logic flush_any;
    logic hit;
    logic beat;
    logic last_beat;

    assign flush_any = flush_i | flush_pend;
    assign hit       = valid[idx_q] && (tags[idx_q] == tag_q);
    assign beat      = (state == REFILL) && mem_rvalid_i;
    assign last_beat = beat && (cnt == OFF_W'(LINE_WORDS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            tag_q      <= '0;
            idx_q      <= '0;
            off_q      <= '0;
            cnt        <= '0;
            resp_q     <= '0;
            valid      <= '0;
            flush_pend <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A flush always wins over a request presented in the same cycle
                    if (flush_any) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end else if (req_valid_i) begin
                        tag_q <= req_addr_i[ADDR_W-1:IDX_W+OFF_W];
                        idx_q <= req_addr_i[IDX_W+OFF_W-1:OFF_W];
                        off_q <= req_addr_i[OFF_W-1:0];
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                        state <= IDLE;
                    end else begin
                        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                        state <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready_i) begin
                        cnt   <= '0;
                        state <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_rvalid_i) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == off_q) resp_q <= mem_rdata_i;
                        if (last_beat) begin
                            valid[idx_q] <= 1'b1;
                            state        <= RESPOND;
                        end
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
            // Flushes seen mid-operation are deferred to the next IDLE cycle
            if (flush_i && state != IDLE) flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (last_beat) tags[idx_q] <= tag_q;
    end

    always_comb begin
        req_ready_o     = (state == IDLE) && !flush_any;
        resp_valid_o    = ((state == LOOKUP) && hit) || (state == RESPOND);
        resp_data_o     = '0;
        if (state == RESPOND)
            resp_data_o = resp_q;
        else if ((state == LOOKUP) && hit)
            resp_data_o = arr_rdata_i;
        arr_we_o        = beat;
        arr_wdata_o     = beat ? mem_rdata_i : '0;
        // Read address is combinational in IDLE so the array read launches on the accept cycle
        if (state == IDLE)
            arr_addr_o  = req_addr_i[IDX_W+OFF_W-1:0];
        else if (state == REFILL)
            arr_addr_o  = {idx_q, cnt};
        else
            arr_addr_o  = {idx_q, off_q};
        mem_req_valid_o = (state == MISS_REQ);
        mem_addr_o      = (state == MISS_REQ) ? {tag_q, idx_q, {OFF_W{1'b0}}} : '0;
    end

    assign hit_cnt_o  = hit_cnt;
    assign miss_cnt_o = miss_cnt;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - randomized bench with transaction-level cache model
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        flush;
    logic        arr_we;
    logic [5:0]  arr_addr;
    logic [7:0]  arr_wdata;
    logic [7:0]  arr_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    cache_refill_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data), .flush_i(flush),
        .arr_we_o(arr_we), .arr_addr_o(arr_addr), .arr_wdata_o(arr_wdata), .arr_rdata_i(arr_rdata),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_addr_o(mem_addr),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:63];
    always @(posedge clk) begin
        if (arr_we) ram[arr_addr] <= arr_wdata;
        arr_rdata <= ram[arr_addr];
    end

    logic [7:0]  mem [logic [31:0]];
    logic [15:0] mv;
    logic [25:0] mtag [16];
    logic [15:0] m_hit, m_miss;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;
    int we_count = 0;
    logic [7:0] last_resp;

    bit          exp_ready, exp_resp, exp_we, exp_mreq, exp_aaddr_chk;
    logic [7:0]  exp_rdata, exp_wdata;
    logic [5:0]  exp_waddr, exp_aaddr;
    logic [31:0] exp_maddr;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = 8'($urandom);
        return mem[a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, exp_ready);
            chk("resp_valid", resp_valid, exp_resp);
            chk("resp_data", resp_data, exp_resp ? exp_rdata : 8'h00);
            chk("arr_we", arr_we, exp_we);
            if (exp_we) begin
                chk("arr_waddr", arr_addr, exp_waddr);
                chk("arr_wdata", arr_wdata, exp_wdata);
            end
            if (exp_aaddr_chk) chk("arr_raddr", arr_addr, exp_aaddr);
            chk("mem_req_valid", mem_req_valid, exp_mreq);
            if (exp_mreq) chk("mem_addr", mem_addr, exp_maddr);
            chk("hit_cnt", hit_cnt, m_hit);
            chk("miss_cnt", miss_cnt, m_miss);
            if (resp_valid) last_resp = resp_data;
            if (arr_we) we_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic base();
        exp_ready = 0; exp_resp = 0; exp_we = 0; exp_mreq = 0; exp_aaddr_chk = 0;
        flush = 0; req_valid = 0; mem_req_ready = 0;
        mem_rvalid = 1'($urandom); mem_rdata = 8'($urandom);
    endtask

    task automatic model_reset();
        mv = '0; m_hit = '0; m_miss = '0;
    endtask

    task automatic do_flush();
        base(); flush = 1; req_valid = 1; req_addr = $urandom; exp_ready = 0;
        tick();
        mv = '0;
    endtask

    task automatic do_req(input logic [31:0] a, input int wt, input int gap, input bit fl_mid, input int rst_beat);
        logic [3:0]  idx;
        logic [7:0]  d;
        bit          hit;
        int          beat;
        bit          v;
        idx = a[5:2];
        hit = mv[idx] && (mtag[idx] == a[31:6]);
        d   = mem_byte(a);
        base(); req_valid = 1; req_addr = a; exp_ready = 1; exp_aaddr_chk = 1; exp_aaddr = a[5:0];
        tick();
        base(); req_addr = $urandom;
        if (hit) begin
            exp_resp = 1; exp_rdata = d;
            tick();
            if (m_hit != 16'hFFFF) m_hit++;
            return;
        end
        tick();
        if (m_miss != 16'hFFFF) m_miss++;
        for (int w = 0; w <= wt; w++) begin
            base(); mem_req_ready = (w == wt); exp_mreq = 1; exp_maddr = {a[31:2], 2'b00};
            tick();
        end
        beat = 0;
        while (beat < 4) begin
            base();
            if (beat == rst_beat) begin
                rst_n = 0; mem_rvalid = 0; exp_ready = 1;
                model_reset();
                tick();
                rst_n = 1;
                for (int s = 0; s < 2; s++) begin
                    base(); mem_rvalid = 1; exp_ready = 1;
                    tick();
                end
                return;
            end
            v = ($urandom_range(0, 99) >= gap);
            mem_rvalid = v;
            if (v) begin
                mem_rdata = mem_byte({a[31:2], 2'(beat)});
                exp_we = 1; exp_waddr = {idx, 2'(beat)}; exp_wdata = mem_rdata;
            end
            if (fl_mid && beat == 1) flush = 1;
            tick();
            if (v) beat++;
        end
        mv[idx] = 1; mtag[idx] = a[31:6];
        base(); exp_resp = 1; exp_rdata = d;
        tick();
        if (fl_mid) begin
            base(); req_valid = 1; req_addr = a; exp_ready = 0;
            tick();
            mv = '0;
        end
    endtask

    task automatic idle_cycle();
        base(); exp_ready = 1;
        tick();
    endtask

    int wc0;
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 8'h00;
        for (int i = 0; i < 4; i++) mem[32'h100 + i] = 8'hA0 + 8'(i);
        model_reset();
        rst_n = 0; req_addr = 0;
        base(); exp_ready = 1;
        chk_en = 1;
        tick(); tick();
        chk("reset_ready", req_ready, 1);
        chk("reset_hit_cnt", hit_cnt, 0);
        rst_n = 1;
        idle_cycle();

        do_req(32'h100, 0, 0, 0, -1);
        chk("cold_miss_data", last_resp, 8'hA0);
        chk("cold_miss_cnt", miss_cnt, 1);
        do_req(32'h102, 0, 0, 0, -1);
        chk("hit_data", last_resp, 8'hA2);
        chk("hit_cnt_one", hit_cnt, 1);
        do_req(32'h500, 0, 0, 0, -1);
        do_req(32'h100, 0, 0, 0, -1);
        chk("conflict_miss_cnt", miss_cnt, 3);

        wc0 = we_count;
        do_req(32'h124, 5, 50, 0, -1);
        chk("gapped_writes", we_count - wc0, 4);

        do_req(32'h101, 0, 0, 0, -1);
        chk("pre_flush_hit", hit_cnt, 2);
        do_flush();
        do_req(32'h100, 0, 0, 0, -1);
        chk("post_flush_miss", miss_cnt, 5);
        do_req(32'h200, 1, 20, 1, -1);
        do_req(32'h100, 0, 0, 0, -1);
        chk("refill_flush_miss", miss_cnt, 7);

        do_req(32'h300, 0, 0, 0, 2);
        chk("mid_reset_cnt", miss_cnt, 0);
        do_req(32'h100, 0, 0, 0, -1);
        chk("after_reset_miss", miss_cnt, 1);
        chk("after_reset_data", last_resp, 8'hA0);

        for (int n = 0; n < 300; n++) begin
            ra[1:0]  = 2'($urandom);
            ra[5:2]  = 4'($urandom);
            ra[31:6] = ($urandom_range(0, 3) == 3) ? 26'h3FFFFFF : 26'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) do_flush();
            if ($urandom_range(0, 3) == 0) idle_cycle();
            do_req(ra, $urandom_range(0, 3), $urandom_range(0, 50), $urandom_range(0, 9) == 0,
                   ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : -1);
        end
        idle_cycle();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
